// File: rtl/term_pkg.sv
// Shared definitions for the 70x30 text terminal: geometry, key codes, writer states
// and the char_buf address/row mapping used by both the writer and the display side.
package term_pkg;

    localparam int unsigned COLS  = 70;
    localparam int unsigned ROWS  = 30;
    localparam int unsigned PROWS = 32;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] ENTER = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;

    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [4:0] LAST_PROW = 5'(PROWS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClearLine,
        StClearAll
    } state_e;

    function automatic logic [14:0] buf_addr(input logic [4:0] prow, input logic [6:0] col);
        return {3'b000, prow, col};
    endfunction

    // Ring mapping: wraps modulo 32 by width.
    function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] offset);
        return lrow + offset;
    endfunction

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/line_end_ram.sv
// 32 x 7 register file holding the end column of each physical row.
// One synchronous write port, one asynchronous read port and a bulk clear.
module line_end_ram
    import term_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic       clr,
    input  logic [4:0] waddr,
    input  logic [6:0] wdata,
    input  logic [4:0] raddr,
    output logic [6:0] rdata
);

    logic [6:0] mem [PROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (clr) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/char_buf_writer.sv
// Writer side of the text-terminal character buffer: accepts keys, writes cells,
// tracks the cursor and per-line end columns, scrolls the ring and clears the screen.
module char_buf_writer
    import term_pkg::*;
(
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [7:0]  key_ascii,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        clr_req,
    output logic [14:0] char_addr,
    output logic [7:0]  char_din,
    output logic        char_wr,
    output logic [6:0]  h_cur,
    output logic [4:0]  v_cur,
    output logic [4:0]  line_offset,
    output logic        busy
);

    state_e     state_q;
    logic [7:0] key_q;
    logic [4:0] clr_row_q;
    logic [6:0] clr_col_q;

    logic [4:0] cur_prow;
    logic [4:0] prev_prow;
    logic [4:0] scroll_prow;
    logic       last_cell;

    logic       le_we;
    logic       le_clr;
    logic [4:0] le_waddr;
    logic [6:0] le_wdata;
    logic [6:0] le_rdata;

    assign cur_prow    = phys_row(v_cur, line_offset);
    assign prev_prow   = phys_row(v_cur - 5'd1, line_offset);
    assign scroll_prow = phys_row(LAST_ROW, line_offset + 5'd1);
    assign last_cell   = (clr_row_q == LAST_PROW) && (clr_col_q == LAST_COL);

    // A pending clear wins over a pending key.
    assign key_ready = (state_q == StIdle) && !clr_req;
    assign busy      = (state_q != StIdle);

    always_comb begin
        le_we    = 1'b0;
        le_clr   = 1'b0;
        le_waddr = cur_prow;
        le_wdata = '0;
        unique case (state_q)
            StWrite: begin
                if (is_printable(key_q) && (h_cur == LAST_COL)) begin
                    le_we    = 1'b1;
                    le_wdata = LAST_COL;
                end else if (key_q == ENTER) begin
                    le_we    = 1'b1;
                    le_wdata = h_cur;
                end
            end
            StClearLine: begin
                if (clr_col_q == LAST_COL) begin
                    le_we    = 1'b1;
                    le_waddr = clr_row_q;
                end
            end
            StClearAll: le_clr = char_wr && last_cell;
            default: ;
        endcase
    end

    line_end_ram u_line_end_ram (
        .clk   (clk_50m),
        .rst   (rst),
        .we    (le_we),
        .clr   (le_clr),
        .waddr (le_waddr),
        .wdata (le_wdata),
        .raddr (prev_prow),
        .rdata (le_rdata)
    );

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q     <= StClearAll;
            key_q       <= '0;
            clr_row_q   <= '0;
            clr_col_q   <= '0;
            h_cur       <= '0;
            v_cur       <= '0;
            line_offset <= '0;
            char_wr     <= 1'b0;
            char_addr   <= '0;
            char_din    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    char_wr <= 1'b0;
                    if (clr_req) begin
                        state_q     <= StClearAll;
                        h_cur       <= '0;
                        v_cur       <= '0;
                        line_offset <= '0;
                        clr_row_q   <= '0;
                        clr_col_q   <= '0;
                        char_wr     <= 1'b1;
                        char_addr   <= buf_addr(5'd0, 7'd0);
                        char_din    <= BLANK;
                    end else if (key_valid) begin
                        // The cell write is issued here so it is visible during WRITE.
                        state_q <= StWrite;
                        key_q   <= key_ascii;
                        if (is_printable(key_ascii)) begin
                            char_wr   <= 1'b1;
                            char_addr <= buf_addr(cur_prow, h_cur);
                            char_din  <= key_ascii;
                        end else if ((key_ascii == BS) && (h_cur != 7'd0)) begin
                            char_wr   <= 1'b1;
                            char_addr <= buf_addr(cur_prow, h_cur - 7'd1);
                            char_din  <= BLANK;
                        end
                    end
                end
                StWrite: begin
                    char_wr <= 1'b0;
                    state_q <= StIdle;
                    if (is_printable(key_q) || (key_q == ENTER)) begin
                        if (is_printable(key_q) && (h_cur != LAST_COL)) begin
                            h_cur <= h_cur + 7'd1;
                        end else begin
                            h_cur <= '0;
                            if (v_cur != LAST_ROW) begin
                                v_cur <= v_cur + 5'd1;
                            end else begin
                                line_offset <= line_offset + 5'd1;
                                state_q     <= StClearLine;
                                clr_row_q   <= scroll_prow;
                                clr_col_q   <= '0;
                                char_wr     <= 1'b1;
                                char_addr   <= buf_addr(scroll_prow, 7'd0);
                                char_din    <= BLANK;
                            end
                        end
                    end else if (key_q == BS) begin
                        if (h_cur != 7'd0) begin
                            h_cur <= h_cur - 7'd1;
                        end else if (v_cur != 5'd0) begin
                            v_cur <= v_cur - 5'd1;
                            h_cur <= le_rdata;
                        end
                    end
                end
                StClearLine: begin
                    if (clr_col_q == LAST_COL) begin
                        char_wr <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        clr_col_q <= clr_col_q + 7'd1;
                        char_addr <= buf_addr(clr_row_q, clr_col_q + 7'd1);
                    end
                end
                StClearAll: begin
                    // After reset char_wr is low, so the first cycle only primes the sweep.
                    if (!char_wr) begin
                        char_wr   <= 1'b1;
                        char_din  <= BLANK;
                        clr_row_q <= '0;
                        clr_col_q <= '0;
                        char_addr <= buf_addr(5'd0, 7'd0);
                    end else if (last_cell) begin
                        char_wr <= 1'b0;
                        state_q <= StIdle;
                    end else if (clr_col_q == LAST_COL) begin
                        clr_col_q <= '0;
                        clr_row_q <= clr_row_q + 5'd1;
                        char_addr <= buf_addr(clr_row_q + 5'd1, 7'd0);
                    end else begin
                        clr_col_q <= clr_col_q + 7'd1;
                        char_addr <= buf_addr(clr_row_q, clr_col_q + 7'd1);
                    end
                end
                default: state_q <= StClearAll;
            endcase
        end
    end

endmodule

// File: doc/char_buf_writer.md
Name: char_buf_writer

Overview:
- Writer side of the 70x30 text-terminal character buffer. Takes translated ASCII keystrokes from the PS/2 path and writes them into char_buf, one cell per cycle.
- Owns the cursor position, per-line end columns, scrolling (line_offset) and full-screen clear.
- Its outputs (h_cur, v_cur, line_offset) feed the display/cursor logic on the read side of the same buffer.

Parameters:
- COLS, 70, visible columns per line (0..COLS-1)
- ROWS, 30, visible lines (0..ROWS-1)
- PROWS, 32, physical rows held in char_buf (ring for scrolling)
- BLANK, 8'h20, fill character for erase/clear

Ports:
- clk_50m  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- key_ascii  input  8  ASCII code of the offered key
- key_valid  input  1  key offer; held until accepted
- key_ready  output  1  writer accepts key this cycle (key_valid & key_ready)
- clr_req  input  1  level request to clear the whole screen
- char_addr  output  15  buffer address = {3'b0, prow[4:0], col[6:0]}
- char_din  output  8  data written to char_buf
- char_wr  output  1  write enable, one cell per cycle
- h_cur  output  7  cursor column, 0..69
- v_cur  output  5  cursor logical row, 0..29
- line_offset  output  5  physical row of logical row 0; prow = (lrow + line_offset) mod 32
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state goes to CLEAR_ALL. h_cur=0, v_cur=0, line_offset=0, all line_end=0, char_wr=0, char_addr=0, char_din=0, key_ready=0, busy=1. The buffer is blanked after every reset.
- States: IDLE, WRITE, CLEAR_LINE, CLEAR_ALL.
- IDLE:
  - key_ready = ~clr_req, so clr_req has priority over a pending key.
  - clr_req=1 -> CLEAR_ALL.
  - Handshake key_valid & key_ready at edge N: latch key_ascii, go to WRITE.
- WRITE (exactly 1 cycle, N+1), by latched code:
  - Printable 0x20-0x7E: char_wr=1, din=code, addr=(prow(v_cur), h_cur). Then:
    - h_cur<69 -> h_cur+1.
    - h_cur==69 -> line_end[prow]=69, h_cur=0, newline.
  - Enter 0x0D: no write. line_end[prow]=h_cur, h_cur=0, newline.
  - Backspace 0x08:
    - h_cur>0 -> char_wr=1, din=BLANK, addr=(prow, h_cur-1), h_cur-1.
    - h_cur==0 and v_cur>0 -> no write; v_cur-1, h_cur=line_end[prow(v_cur-1)].
    - (0,0) -> no-op.
  - Any other code: ignored, no write, cursor unchanged.
  - Next state: IDLE, or CLEAR_LINE if a scroll occurred.
  - key_ready re-asserts at cycle N+2 at the earliest, so maximum throughput is 1 key per 2 cycles.
- Newline:
  - v_cur<29 -> v_cur+1.
  - v_cur==29 -> scroll: v_cur stays 29, line_offset+1 (wraps 31->0), go to CLEAR_LINE for new prow = (29 + new offset) mod 32.
- CLEAR_LINE: 70 cycles, char_wr=1, din=BLANK, col 0..69 of the target prow. Sets line_end[prow]=0, then goes to IDLE.
- CLEAR_ALL:
  - On entry: line_offset=0, h_cur=0, v_cur=0.
  - Writes BLANK to prow 0..31, col 0..69, col fastest: 2240 cycles with char_wr=1 every cycle. Cols 70..127 are never written.
  - All line_end=0; then IDLE.
  - clr_req asserted during CLEAR_ALL or CLEAR_LINE is not re-armed until IDLE samples it again.
- char_wr is 0 in IDLE. char_addr/char_din hold their last value when char_wr=0.
- Reset mid-clear or mid-write aborts immediately and restarts CLEAR_ALL.
- All counters are sized exactly: col 7b, row 5b, line_offset 5b modulo-32 wrap; no other arithmetic overflows.

Decomposition:
- Shared package term_pkg: COLS, ROWS, PROWS, BLANK, ASCII codes (ENTER 8'h0D, BS 8'h08), state enum, and an address function {3'b0, prow, col}. The display side uses the same package for address and offset mapping.
- One natural sub-module: line_end_ram (32 x 7 register file, 1 write + 1 async read port).

Test Plan:
- After reset release, count char_wr pulses -> exactly 2240 writes of 8'h20; last addr = {3'b0,5'd31,7'd69}; then key_ready=1, h_cur=0, v_cur=0.
- Send 'A' (8'h41) at (0,0) -> next cycle char_wr=1, char_addr=15'h0000, char_din=8'h41; afterwards h_cur=1; key_ready low for exactly 1 cycle.
- Type 70 'x' then Enter -> wrap after 70th char to (1,0), line_end[0]=69; Enter -> (2,0), line_end[1]=0. Backspace twice from (2,0) -> (1,0), then (0,69) with no writes.
- Backspace at (0,3) -> write 8'h20 to addr 15'h0002, h_cur=2; backspace at (0,0) -> no write, no change.
- Cursor at (29,5), send Enter -> line_offset 0->1, v_cur=29, h_cur=0; then 70 writes of 8'h20 to prow 30 (addr 15'h0F00..15'h0F45), busy high throughout. Repeat until line_offset wraps 31->0.
- clr_req and key_valid asserted together in IDLE -> key not accepted (key_ready=0), CLEAR_ALL runs 2240 cycles, line_offset=0, cursor (0,0); the key is then accepted.
